// File: rtl/alu32_dispatch.sv
// alu32_dispatch: command-side initiator for the alu32 compute unit.
// Accepts keyed commands, drives the ALU until its key_out matches the issued
// key (or a timeout expires), clears the ALU for one cycle and returns the
// result on a valid/ready response stream.
// Optional build macro ALU_DISPATCH_SKID_EN adds a one-entry command buffer so
// a command can be accepted while an operation is still in flight.
module alu32_dispatch #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [7:0]  OP_ADD         = 8'h01,
  parameter logic [7:0]  OP_SUB         = 8'h02,
  parameter logic [7:0]  OP_MUL         = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic [7:0]  cmd_key,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        alu_en,
  output logic        alu_clr,
  output logic [7:0]  alu_op,
  output logic [7:0]  alu_key,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic [7:0]  alu_key_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_key,
  output logic [31:0] res_data,
  output logic        res_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CLEAR = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Opcodes are forwarded to the ALU unchanged; the named codes are not decoded here.
  logic unused_opcodes_s;
  assign unused_opcodes_s = ^{OP_ADD, OP_SUB, OP_MUL};

  state_t      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  key_q, key_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  res_key_q, res_key_d;
  logic [31:0] res_data_q, res_data_d;
  logic        res_err_q, res_err_d;
  // Set when the response was already handed off during CLEAR.
  logic        taken_q, taken_d;

  // Command source seen by IDLE (buffer entry first in the skid build).
  logic        load_s;
  logic [7:0]  src_op_s;
  logic [7:0]  src_key_s;
  logic [31:0] src_a_s;
  logic [31:0] src_b_s;
  logic        cmd_fire_s;
  logic        match_s;
  logic        timeout_s;

`ifdef ALU_DISPATCH_SKID_EN
  logic        buf_full_q, buf_full_d;
  logic [7:0]  buf_op_q, buf_op_d;
  logic [7:0]  buf_key_q, buf_key_d;
  logic [31:0] buf_a_q, buf_a_d;
  logic [31:0] buf_b_q, buf_b_d;

  // In IDLE the entry is freed in the same cycle, so a new command always fits.
  assign cmd_ready  = !buf_full_q || (state_q == S_IDLE);
  assign cmd_fire_s = cmd_valid && cmd_ready;
  assign load_s     = (state_q == S_IDLE) && (buf_full_q || cmd_valid);
  assign src_op_s   = buf_full_q ? buf_op_q  : cmd_op;
  assign src_key_s  = buf_full_q ? buf_key_q : cmd_key;
  assign src_a_s    = buf_full_q ? buf_a_q   : cmd_a;
  assign src_b_s    = buf_full_q ? buf_b_q   : cmd_b;

  // Skid buffer next-state: store commands that cannot be loaded directly.
  always_comb begin
    buf_full_d = buf_full_q;
    buf_op_d   = buf_op_q;
    buf_key_d  = buf_key_q;
    buf_a_d    = buf_a_q;
    buf_b_d    = buf_b_q;
    if ((state_q == S_IDLE) && !buf_full_q) begin
      buf_full_d = 1'b0;
    end else if (cmd_fire_s) begin
      buf_full_d = 1'b1;
      buf_op_d   = cmd_op;
      buf_key_d  = cmd_key;
      buf_a_d    = cmd_a;
      buf_b_d    = cmd_b;
    end else if (state_q == S_IDLE) begin
      buf_full_d = 1'b0;
    end else begin
      buf_full_d = buf_full_q;
    end
  end

  // Skid buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full_q <= 1'b0;
      buf_op_q   <= 8'h00;
      buf_key_q  <= 8'h00;
      buf_a_q    <= 32'h0000_0000;
      buf_b_q    <= 32'h0000_0000;
    end else begin
      buf_full_q <= buf_full_d;
      buf_op_q   <= buf_op_d;
      buf_key_q  <= buf_key_d;
      buf_a_q    <= buf_a_d;
      buf_b_q    <= buf_b_d;
    end
  end
`else
  assign cmd_ready  = (state_q == S_IDLE);
  assign cmd_fire_s = cmd_valid && cmd_ready;
  assign load_s     = cmd_fire_s;
  assign src_op_s   = cmd_op;
  assign src_key_s  = cmd_key;
  assign src_a_s    = cmd_a;
  assign src_b_s    = cmd_b;
`endif

  assign match_s   = (alu_key_out == key_q);
  assign timeout_s = (cnt_q == TIMEOUT_LAST);

  // FSM next-state and response capture.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    key_d      = key_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    res_key_d  = res_key_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    taken_d    = taken_q;
    case (state_q)
      S_IDLE: begin
        if (load_s) begin
          op_d    = src_op_s;
          key_d   = src_key_s;
          a_d     = src_a_s;
          b_d     = src_b_s;
          cnt_d   = 8'd0;
          taken_d = 1'b0;
          if (src_key_s != 8'h00) begin
            state_d = S_WAIT;
          end else begin
            // Illegal key: answer with an error, never touch the ALU.
            state_d    = S_RESP;
            res_err_d  = 1'b1;
            res_key_d  = 8'h00;
            res_data_d = 32'h0000_0000;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (match_s) begin
          // Match has priority over a coincident timeout.
          res_data_d = alu_out;
          res_key_d  = key_q;
          res_err_d  = 1'b0;
          state_d    = S_CLEAR;
        end else if (timeout_s) begin
          res_data_d = 32'h0000_0000;
          res_key_d  = key_q;
          res_err_d  = 1'b1;
          state_d    = S_CLEAR;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_CLEAR: begin
        state_d = S_RESP;
        taken_d = res_ready;
      end
      S_RESP: begin
        if (taken_q || res_ready) begin
          state_d = S_IDLE;
          taken_d = 1'b0;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
        taken_d = 1'b0;
      end
    endcase
  end

  // FSM state and holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 8'h00;
      key_q      <= 8'h00;
      a_q        <= 32'h0000_0000;
      b_q        <= 32'h0000_0000;
      cnt_q      <= 8'd0;
      res_key_q  <= 8'h00;
      res_data_q <= 32'h0000_0000;
      res_err_q  <= 1'b0;
      taken_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      key_q      <= key_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      res_key_q  <= res_key_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      taken_q    <= taken_d;
    end
  end

  // ALU drive: held operands only in WAIT; enable drops in the match cycle.
  assign alu_en  = (state_q == S_WAIT) && (alu_key_out != key_q);
  assign alu_clr = (state_q == S_CLEAR);
  assign alu_op  = (state_q == S_WAIT) ? op_q  : 8'h00;
  assign alu_key = (state_q == S_WAIT) ? key_q : 8'h00;
  assign alu_a   = (state_q == S_WAIT) ? a_q   : 32'h0000_0000;
  assign alu_b   = (state_q == S_WAIT) ? b_q   : 32'h0000_0000;

  // Response is valid from CLEAR until handed off.
  assign res_valid = (state_q == S_CLEAR) || ((state_q == S_RESP) && !taken_q);
  assign res_key   = res_key_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu32_dispatch.sv
// Directed bench for alu32_dispatch with a small behavioural alu32 model.
module tb_alu32_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [7:0]  cmd_key;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        alu_en;
  logic        alu_clr;
  logic [7:0]  alu_op;
  logic [7:0]  alu_key;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic [7:0]  alu_key_out;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_key;
  logic [31:0] res_data;
  logic        res_err;

  int checks = 0;
  int errors = 0;
  int en_cycles = 0;
  int clr_cycles = 0;
  int e0;
  int c0;
  int lat;

  logic [31:0] m_out;
  logic [7:0]  m_key;
  logic [1:0]  m_cnt;
  logic        stub_dead;

  always #5 clk = ~clk;

  alu32_dispatch dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_key(cmd_key), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_en(alu_en), .alu_clr(alu_clr), .alu_op(alu_op), .alu_key(alu_key),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_key_out(alu_key_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_key(res_key),
    .res_data(res_data), .res_err(res_err)
  );

  // alu32 model: ADD/SUB one enabled cycle, MUL four, holds when not enabled.
  assign alu_key_out = stub_dead ? 8'h00 : m_key;
  assign alu_out     = m_out;

  always @(posedge clk) begin
    if (rst || alu_clr) begin
      m_key <= 8'h00;
      m_cnt <= 2'd0;
      if (rst) m_out <= 32'h0000_0000;
    end else if (alu_en) begin
      case (alu_op)
        8'h01: begin m_out <= alu_a + alu_b; m_key <= alu_key; end
        8'h02: begin m_out <= alu_a - alu_b; m_key <= alu_key; end
        8'h03: begin
          if (m_cnt == 2'd3) begin
            m_out <= alu_a * alu_b;
            m_key <= alu_key;
            m_cnt <= 2'd0;
          end else begin
            m_cnt <= m_cnt + 2'd1;
            m_key <= 8'h00;
          end
        end
        default: begin m_out <= 32'h0000_0000; m_key <= alu_key; end
      endcase
    end
  end

  // Count enable and clear cycles as seen by the ALU.
  always @(posedge clk) begin
    if (alu_en === 1'b1) en_cycles <= en_cycles + 1;
    if (alu_clr === 1'b1) clr_cycles <= clr_cycles + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one command for a single accept cycle; returns in cycle T+1.
  task automatic send(input logic [7:0] op, input logic [7:0] key,
                      input logic [31:0] a, input logic [31:0] b);
    cmd_op    = op;
    cmd_key   = key;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 8'h00; cmd_key = 8'h00;
    cmd_a = 32'h0; cmd_b = 32'h0; res_ready = 1'b1; stub_dead = 1'b0;
    tick(); tick(); tick();
    chk("rst_res_valid", {31'h0, res_valid}, 32'd0);
    chk("rst_alu_en", {31'h0, alu_en}, 32'd0);
    chk("rst_alu_clr", {31'h0, alu_clr}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_err", {31'h0, res_err}, 32'd0);
    chk("rst_alu_key", {24'h0, alu_key}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_cmd_ready", {31'h0, cmd_ready}, 32'd1);

    // ADD 5+7, key 11
    e0 = en_cycles; c0 = clr_cycles;
    send(8'h01, 8'h11, 32'd5, 32'd7);
    chk("add_t1_en", {31'h0, alu_en}, 32'd1);
    chk("add_t1_key", {24'h0, alu_key}, 32'h11);
    chk("add_t1_a", alu_a, 32'd5);
    chk("add_t1_cmd_ready", {31'h0, cmd_ready}, 32'd0);
    tick();
    chk("add_t2_en", {31'h0, alu_en}, 32'd0);
    chk("add_t2_valid", {31'h0, res_valid}, 32'd0);
    tick();
    chk("add_t3_valid", {31'h0, res_valid}, 32'd1);
    chk("add_t3_data", res_data, 32'd12);
    chk("add_t3_key", {24'h0, res_key}, 32'h11);
    chk("add_t3_err", {31'h0, res_err}, 32'd0);
    chk("add_t3_clr", {31'h0, alu_clr}, 32'd1);
    tick();
    chk("add_t4_clr", {31'h0, alu_clr}, 32'd0);
    chk("add_t4_valid", {31'h0, res_valid}, 32'd0);
    tick();
    chk("add_idle_ready", {31'h0, cmd_ready}, 32'd1);
    chk("add_en_cycles", en_cycles - e0, 32'd1);
    chk("add_clr_cycles", clr_cycles - c0, 32'd1);

    // SUB 3-10
    send(8'h02, 8'h12, 32'd3, 32'd10);
    tick(); tick();
    chk("sub_valid", {31'h0, res_valid}, 32'd1);
    chk("sub_data", res_data, 32'hFFFF_FFF9);
    tick(); tick();

    // MUL -6*7, key 22
    e0 = en_cycles;
    send(8'h03, 8'h22, 32'hFFFF_FFFA, 32'd7);
    chk("mul_t1_en", {31'h0, alu_en}, 32'd1);
    chk("mul_t1_op", {24'h0, alu_op}, 32'h03);
    tick(); tick(); tick();
    chk("mul_t4_en", {31'h0, alu_en}, 32'd1);
    tick();
    chk("mul_t5_en", {31'h0, alu_en}, 32'd0);
    chk("mul_t5_valid", {31'h0, res_valid}, 32'd0);
    tick();
    chk("mul_t6_valid", {31'h0, res_valid}, 32'd1);
    chk("mul_t6_data", res_data, 32'hFFFF_FFD6);
    chk("mul_t6_key", {24'h0, res_key}, 32'h22);
    chk("mul_en_cycles", en_cycles - e0, 32'd4);
    tick(); tick();

    // Illegal key 0
    e0 = en_cycles;
    send(8'h01, 8'h00, 32'd9, 32'd9);
    chk("ill_valid", {31'h0, res_valid}, 32'd1);
    chk("ill_err", {31'h0, res_err}, 32'd1);
    chk("ill_data", res_data, 32'd0);
    chk("ill_key", {24'h0, res_key}, 32'd0);
    chk("ill_en", {31'h0, alu_en}, 32'd0);
    tick();
    chk("ill_idle_ready", {31'h0, cmd_ready}, 32'd1);
    chk("ill_en_cycles", en_cycles - e0, 32'd0);

    // Unknown opcode forwarded unchanged
    send(8'h7F, 8'h55, 32'd1, 32'd2);
    chk("unk_op", {24'h0, alu_op}, 32'h7F);
    tick(); tick();
    chk("unk_valid", {31'h0, res_valid}, 32'd1);
    chk("unk_key", {24'h0, res_key}, 32'h55);
    tick(); tick();

    // Timeout: ALU never answers
    stub_dead = 1'b1;
    e0 = en_cycles; c0 = clr_cycles;
    send(8'h01, 8'h66, 32'd1, 32'd1);
    for (int i = 0; i < 15; i++) tick();
    chk("to_t16_en", {31'h0, alu_en}, 32'd1);
    chk("to_t16_valid", {31'h0, res_valid}, 32'd0);
    tick();
    chk("to_valid", {31'h0, res_valid}, 32'd1);
    chk("to_err", {31'h0, res_err}, 32'd1);
    chk("to_key", {24'h0, res_key}, 32'h66);
    chk("to_data", res_data, 32'd0);
    chk("to_clr", {31'h0, alu_clr}, 32'd1);
    chk("to_en_cycles", en_cycles - e0, 32'd16);
    stub_dead = 1'b0;
    tick();
    chk("to_clr_cycles", clr_cycles - c0, 32'd1);
    tick();

    // Backpressure: response held for 10 cycles
    res_ready = 1'b0;
    send(8'h01, 8'h33, 32'd100, 32'd23);
    tick(); tick();
    chk("bp_valid", {31'h0, res_valid}, 32'd1);
    chk("bp_data", res_data, 32'd123);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", {31'h0, res_valid}, 32'd1);
      chk("bp_hold_data", res_data, 32'd123);
      chk("bp_hold_key", {24'h0, res_key}, 32'h33);
`ifndef ALU_DISPATCH_SKID_EN
      chk("bp_hold_cmd_ready", {31'h0, cmd_ready}, 32'd0);
`endif
    end
    res_ready = 1'b1;
    tick();
    chk("bp_done_valid", {31'h0, res_valid}, 32'd0);
    chk("bp_done_ready", {31'h0, cmd_ready}, 32'd1);

    // Reset in the middle of a MUL
    send(8'h03, 8'h77, 32'd5, 32'd5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_valid", {31'h0, res_valid}, 32'd0);
    chk("rstmid_en", {31'h0, alu_en}, 32'd0);
    chk("rstmid_ready", {31'h0, cmd_ready}, 32'd1);
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (res_valid !== 1'b0) lat++;
    end
    chk("rstmid_no_resp", lat, 32'd0);
    send(8'h03, 8'h44, 32'd3, 32'hFFFF_FFFB);
    lat = 1;
    for (int i = 0; i < 20 && res_valid !== 1'b1; i++) begin
      tick();
      lat++;
    end
    chk("post_rst_valid", {31'h0, res_valid}, 32'd1);
    chk("post_rst_latency", lat, 32'd6);
    chk("post_rst_data", res_data, 32'hFFFF_FFF1);
    chk("post_rst_key", {24'h0, res_key}, 32'h44);
    chk("post_rst_err", {31'h0, res_err}, 32'd0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu32_dispatch.md
Name: alu32_dispatch

Overview:
- Command-side initiator for the alu32 compute unit.
- Accepts keyed arithmetic commands over a valid/ready stream and drives the ALU's en/op/key_in/inA/inB inputs, holding them stable for as many cycles as the op needs.
- Detects completion by matching the ALU's key_out against the issued key, then returns result+key on a valid/ready response stream.
- Sits between the command decoder (host link) and alu32; provides timeout recovery and ALU clearing between ops.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in WAIT before the op is aborted with an error (range 5..255).
- OP_ADD, 8'h01: add opcode, forwarded unchanged.
- OP_SUB, 8'h02: subtract opcode, forwarded unchanged.
- OP_MUL, 8'h03: multiply opcode, forwarded unchanged.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high; clock clk
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accept
- cmd_op  in  8  opcode
- cmd_key  in  8  tag; 0 is illegal
- cmd_a  in  32  operand A
- cmd_b  in  32  operand B
- alu_en  out  1  ALU enable
- alu_clr  out  1  ALU synchronous clear
- alu_op  out  8  ALU opcode
- alu_key  out  8  ALU key_in
- alu_a  out  32  ALU inA
- alu_b  out  32  ALU inB
- alu_out  in  32  ALU result
- alu_key_out  in  8  ALU key_out; 0 = busy/no result
- res_valid  out  1  response valid
- res_ready  in  1  response accept
- res_key  out  8  tag of response
- res_data  out  32  result (0 on error)
- res_err  out  1  1 = timeout or illegal key

Behaviour:
- States: IDLE, WAIT, CLEAR, RESP. Reset: state=IDLE, all outputs 0, internal regs 0, timeout counter 0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch op/key/a/b into holding regs; clear the counter.
  - key!=0 → WAIT.
  - key==0 → RESP with res_err=1, res_key=0, res_data=0; the ALU is not touched.
- WAIT:
  - alu_op/alu_key/alu_a/alu_b come from the holding regs, stable for the whole state.
  - alu_en = (alu_key_out != held key), combinational, so en drops in the match cycle and the ALU holds.
  - Counter increments each WAIT cycle.
  - Match → latch res_data=alu_out, res_key=key, res_err=0; go to CLEAR.
  - Counter == TIMEOUT_CYCLES-1 without match → res_data=0, res_err=1, res_key=key; go to CLEAR.
  - If match and timeout coincide, the match wins.
- CLEAR:
  - alu_clr=1 and alu_en=0 for exactly one cycle; removes stale key_out and resets the ALU MUL state.
  - res_valid=1 from this cycle onward.
  - Next state is RESP regardless of res_ready; a handshake taken in CLEAR counts.
- RESP: res_valid=1 until res_valid&&res_ready, then IDLE. res_* are stable while valid and not ready.
- alu_* outputs are 0 outside WAIT, except alu_clr in CLEAR. cmd_ready=0 outside IDLE (base build).
- Latency from accept edge T:
  - ADD/SUB/unknown op: en high at T+1, match at T+2, res_valid at T+3.
  - MUL: en high T+1..T+4, match at T+5, res_valid at T+6.
- Throughput: next command is accepted no earlier than the cycle after the response handshake.
- rst in any state returns to IDLE within one edge and drops res_valid; no response is issued for the aborted op.

Optional Feature:
- Macro: ALU_DISPATCH_SKID_EN.
- Defined:
  - Adds a one-entry command buffer; cmd_ready = !buf_full in all states.
  - A command accepted while not in IDLE is stored. IDLE loads from the buffer first, in the cycle IDLE is entered, and frees the buffer that cycle.
  - A command arriving in the same cycle as that load is accepted into the freed entry.
  - Illegal-key check applies on load. Reset empties the buffer.
- Undefined: no buffer; cmd_ready=1 only in IDLE.

Test Plan:
- ADD, key=8'h11, a=5, b=7, res_ready=1 → res_valid at T+3, res_key=8'h11, res_data=12, res_err=0; alu_clr high exactly one cycle.
- SUB a=3, b=10 → res_data=32'hFFFFFFF9; MUL a=-6, b=7, key=8'h22 → alu_en high 4 cycles, res_data=32'hFFFFFFD6 at T+6.
- Illegal key: cmd_key=0 → RESP with res_err=1, res_data=0; alu_en never asserted.
- Timeout: alu_key_out tied 0 by a stub → alu_en high 16 cycles, then res_err=1, res_key=issued key, alu_clr pulse.
- Backpressure: res_ready=0 for 10 cycles → res_* stable and cmd_ready=0; with ALU_DISPATCH_SKID_EN, a second ADD is accepted and completes 3 cycles after the first handshake.
- rst asserted mid-MUL (T+2) → res_valid never rises; the next command completes normally with the correct product.
